sh_frame_ctrl: RTL

Receive-frame controller that sequences the SH_SYNC bit recovery path. It enables SH_SYNC while `RX` is high and collects each recovered bit strobed by `sh_en` into a 63-bit sliding window. It detects a frame by its three fixed sync fields, then hands the frame to the transmit side with a valid/ready handshake on `tx_rdy`. A bit-gap watchdog discards partially received frames.

---
 rtl/sh_ctrl_pkg.sv | 20 ++
 rtl/sh_bit_watchdog.sv | 39 +++
 rtl/sh_frame_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sh_ctrl_pkg.sv
// rtl/sh_ctrl_pkg.sv - shared types and constants for the SH_SYNC receive-frame controller
package sh_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HUNT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int             FRAME_BITS     = 63;
    localparam logic [62:0]    SYNC_MASK      = 63'h7C00_001F_0000_01FF;
    localparam logic [62:0]    SYNC_VAL       = 63'h7C00_001F_0000_01FF;
    localparam int             BIT_PERIOD_CYC = 10000;
    localparam int             TIMEOUT_CYC    = 3 * BIT_PERIOD_CYC;

    function automatic logic sync_hit(input logic [FRAME_BITS-1:0] win);
        return (win & SYNC_MASK) == SYNC_VAL;
    endfunction

endpackage

// File: rtl/sh_bit_watchdog.sv
// rtl/sh_bit_watchdog.sv - bit-gap watchdog; expire pulses when LIMIT cycles pass without a kick
module sh_bit_watchdog
    import sh_ctrl_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic kick,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A kick in the expiry cycle suppresses the pulse and restarts the count.
    assign expire = arm && !kick && (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (kick || !arm || expire) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sh_frame_ctrl.sv
// rtl/sh_frame_ctrl.sv - SH_SYNC receive-frame controller; watchdog built under SH_FRAME_CTRL_TIMEOUT_EN
module sh_frame_ctrl
    import sh_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX,
    input  logic                  sh_en,
    input  logic                  bit_in,
    input  logic                  tx_rdy,
    output logic                  rx_en,
    output logic                  frame_vld,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  ovf,
    output logic                  timeout,
    output logic [1:0]            state
);

    state_e                  state_q;
    logic [FRAME_BITS-1:0]   window_q;
    logic [5:0]              bits_seen_q;
    logic [FRAME_BITS-1:0]   frame_q;
    logic                    frame_vld_q;
    logic                    rx_en_q;
    logic                    ovf_q;
    logic                    timeout_q;

    logic [FRAME_BITS-1:0]   win_shift;
    logic [5:0]              bits_inc;
    logic                    match;
    logic                    wd_expire;

    assign win_shift = {window_q[FRAME_BITS-2:0], bit_in};
    assign bits_inc  = (bits_seen_q == 6'd63) ? 6'd63 : bits_seen_q + 6'd1;
    assign match     = (bits_inc == 6'd63) && sync_hit(win_shift);

`ifdef SH_FRAME_CTRL_TIMEOUT_EN
    logic wd_arm;

    assign wd_arm = (state_q == ST_HUNT) && (bits_seen_q != 6'd0);

    sh_bit_watchdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .arm    (wd_arm),
        .kick   (sh_en),
        .expire (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            window_q    <= '0;
            bits_seen_q <= '0;
            frame_q     <= '0;
            frame_vld_q <= 1'b0;
            rx_en_q     <= 1'b0;
            ovf_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            ovf_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (RX) begin
                        state_q     <= ST_HUNT;
                        rx_en_q     <= 1'b1;
                        window_q    <= '0;
                        bits_seen_q <= '0;
                    end
                end
                ST_HUNT: begin
                    if (!RX) begin
                        state_q     <= ST_IDLE;
                        rx_en_q     <= 1'b0;
                        window_q    <= '0;
                        bits_seen_q <= '0;
                    end else if (sh_en) begin
                        window_q    <= win_shift;
                        bits_seen_q <= bits_inc;
                        if (match) begin
                            frame_q     <= win_shift;
                            frame_vld_q <= 1'b1;
                            state_q     <= ST_HOLD;
                            rx_en_q     <= 1'b0;
                        end
                    end else if (wd_expire) begin
                        window_q    <= '0;
                        bits_seen_q <= '0;
                        timeout_q   <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // SH_SYNC is disabled here, so any strobe is an overrun.
                    if (sh_en) begin
                        ovf_q <= 1'b1;
                    end
                    if (tx_rdy) begin
                        frame_vld_q <= 1'b0;
                        window_q    <= '0;
                        bits_seen_q <= '0;
                        state_q     <= RX ? ST_HUNT : ST_IDLE;
                        rx_en_q     <= RX;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rx_en_q     <= 1'b0;
                    frame_vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_en      = rx_en_q;
    assign frame_vld  = frame_vld_q;
    assign frame_data = frame_q;
    assign ovf        = ovf_q;
    assign timeout    = timeout_q;
    assign state      = state_q;

endmodule
